// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        SHOW    = 2'b11
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b1000;

    // True when exactly one bit of the op event vector is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_sync_edge.sv
// Synchronizer chain plus registered rising-edge detector for raw buttons.
// All synchronizer and history flops reset to 1, so a button held through
// reset release produces no event until it is released and pressed again.
module btn_sync_edge #(
    parameter int W           = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] pulse
);

    logic [SYNC_STAGES-1:0][W-1:0] sync;
    logic [W-1:0]                  hist;

    // Shift raw buttons through the chain and emit a one-cycle registered
    // pulse on each synchronized 0->1 transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '1;
            hist  <= '1;
            pulse <= '0;
        end else begin
            sync[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync[i] <= sync[i-1];
            hist  <= sync[SYNC_STAGES-1];
            pulse <= sync[SYNC_STAGES-1] & ~hist;
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front-end controller that sequences operand A, operand B and the one-hot
// op code into the lab ALU. All outputs come straight from flops.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int n           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] sw,
    input  logic         btn_enter,
    input  logic         btn_undo,
    input  logic [3:0]   btn_op,
    output logic [n-1:0] numeroA,
    output logic [n-1:0] numeroB,
    output logic [3:0]   button,
    output logic         result_valid,
    output logic [1:0]   state_o
);

    logic [5:0] ev;
    logic       ev_enter;
    logic       ev_undo;
    logic [3:0] ev_op;
    state_t     state;

    btn_sync_edge #(
        .W           (6),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .raw   ({btn_op, btn_undo, btn_enter}),
        .pulse (ev)
    );

    assign ev_enter = ev[0];
    assign ev_undo  = ev[1];
    assign ev_op    = ev[5:2];
    assign state_o  = state;

    // Operand/op FSM. UNDO beats ENTER beats op, but an event that the
    // current state ignores never blocks a lower-priority one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_A;
            numeroA      <= '0;
            numeroB      <= '0;
            button       <= 4'b0000;
            result_valid <= 1'b0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (ev_enter) begin
                        numeroA <= sw;
                        state   <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (ev_undo) begin
                        state <= WAIT_A;
                    end else if (ev_enter) begin
                        numeroB <= sw;
                        state   <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (ev_undo) begin
                        state <= WAIT_B;
                    end else if (is_onehot4(ev_op)) begin
                        button       <= ev_op;
                        result_valid <= 1'b1;
                        state        <= SHOW;
                    end
                end
                SHOW: begin
                    if (ev_undo) begin
                        button       <= 4'b0000;
                        result_valid <= 1'b0;
                        state        <= WAIT_OP;
                    end else if (ev_enter) begin
                        button       <= 4'b0000;
                        result_valid <= 1'b0;
                        state        <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small reference ALU.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       btn_enter = 1'b0;
    logic       btn_undo = 1'b0;
    logic [3:0] btn_op = 4'b0000;
    logic [7:0] numeroA, numeroB;
    logic [3:0] button;
    logic       result_valid;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    alu_operand_sequencer #(.n(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .btn_enter    (btn_enter),
        .btn_undo     (btn_undo),
        .btn_op       (btn_op),
        .numeroA      (numeroA),
        .numeroB      (numeroB),
        .button       (button),
        .result_valid (result_valid),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Lab ALU as wired alongside the sequencer: default branch gives 0.
    function automatic logic [7:0] alu(input logic [7:0] a, b, input logic [3:0] op);
        case (op)
            4'b0001: return a + b;
            4'b0010: return a - b;
            4'b0100: return a & b;
            4'b1000: return a | b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the given buttons for two cycles, release, and allow the event
    // to propagate through sync, edge detect and FSM.
    task automatic press(input logic e, input logic u, input logic [3:0] o);
        @(negedge clk);
        btn_enter = e;
        btn_undo  = u;
        btn_op    = o;
        repeat (2) @(negedge clk);
        btn_enter = 1'b0;
        btn_undo  = 1'b0;
        btn_op    = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_numeroA", numeroA, 8'h00);
        check("rst_numeroB", numeroB, 8'h00);
        check("rst_button", button, 4'b0000);
        check("rst_valid", result_valid, 1'b0);
        check("rst_state", state_o, 2'b00);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1. Normal flow: 25 - 13
        sw = 8'h25; press(1'b1, 1'b0, 4'b0000);
        check("t1_stateB", state_o, 2'b01);
        sw = 8'h13; press(1'b1, 1'b0, 4'b0000);
        check("t1_stateOP", state_o, 2'b10);
        check("t1_button_pre", button, 4'b0000);
        press(1'b0, 1'b0, 4'b0010);
        check("t1_numeroA", numeroA, 8'h25);
        check("t1_numeroB", numeroB, 8'h13);
        check("t1_button", button, 4'b0010);
        check("t1_valid", result_valid, 1'b1);
        check("t1_state", state_o, 2'b11);
        check("t1_alu", alu(numeroA, numeroB, button), 8'h12);
        press(1'b1, 1'b0, 4'b0000);
        check("t1_end_button", button, 4'b0000);
        check("t1_end_valid", result_valid, 1'b0);
        check("t1_end_state", state_o, 2'b00);
        check("t1_end_alu", alu(numeroA, numeroB, button), 8'h00);

        // 2. Wrap-around add: F0 + 20
        sw = 8'hF0; press(1'b1, 1'b0, 4'b0000);
        sw = 8'h20; press(1'b1, 1'b0, 4'b0000);
        press(1'b0, 1'b0, 4'b0001);
        check("t2_button", button, 4'b0001);
        check("t2_alu", alu(numeroA, numeroB, button), 8'h10);
        press(1'b0, 1'b1, 4'b0000);
        check("t2_undo_state", state_o, 2'b10);
        check("t2_undo_button", button, 4'b0000);

        // 3. Invalid op (two bits at once), then a single OR
        press(1'b0, 1'b0, 4'b0101);
        check("t3_bad_state", state_o, 2'b10);
        check("t3_bad_button", button, 4'b0000);
        check("t3_bad_valid", result_valid, 1'b0);
        press(1'b0, 1'b0, 4'b1000);
        check("t3_or_button", button, 4'b1000);
        check("t3_or_state", state_o, 2'b11);
        check("t3_or_alu", alu(numeroA, numeroB, button), 8'hF0);

        // 4. UNDO chain
        press(1'b0, 1'b1, 4'b0000);
        check("t4_u1_state", state_o, 2'b10);
        check("t4_u1_button", button, 4'b0000);
        check("t4_u1_A", numeroA, 8'hF0);
        check("t4_u1_B", numeroB, 8'h20);
        press(1'b0, 1'b1, 4'b0000);
        check("t4_u2_state", state_o, 2'b01);
        press(1'b0, 1'b1, 4'b0000);
        check("t4_u3_state", state_o, 2'b00);
        check("t4_u3_A", numeroA, 8'hF0);
        sw = 8'h77; press(1'b1, 1'b0, 4'b0000);
        check("t4_A77", numeroA, 8'h77);
        check("t4_stateB", state_o, 2'b01);
        sw = 8'h99; press(1'b1, 1'b1, 4'b0000);
        check("t4_prio_state", state_o, 2'b00);
        check("t4_prio_B", numeroB, 8'h20);

        // 5. Latency and held button
        sw = 8'h3C;
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("t5_lat3_A", numeroA, 8'h77);
        @(posedge clk);
        #1 check("t5_lat4_A", numeroA, 8'h3C);
        check("t5_lat4_state", state_o, 2'b01);
        repeat (16) @(negedge clk);
        check("t5_held_state", state_o, 2'b01);
        btn_enter = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_rel_state", state_o, 2'b01);

        // 6. Async reset from SHOW, button held across reset release
        sw = 8'h05; press(1'b1, 1'b0, 4'b0000);
        press(1'b0, 1'b0, 4'b0100);
        check("t6_pre_state", state_o, 2'b11);
        @(posedge clk);
        #3 reset = 1'b1;
        btn_enter = 1'b1;
        #1;
        check("t6_async_A", numeroA, 8'h00);
        check("t6_async_B", numeroB, 8'h00);
        check("t6_async_button", button, 4'b0000);
        check("t6_async_valid", result_valid, 1'b0);
        check("t6_async_state", state_o, 2'b00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sw = 8'hAA;
        repeat (8) @(negedge clk);
        check("t6_held_state", state_o, 2'b00);
        check("t6_held_A", numeroA, 8'h00);
        btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        sw = 8'h5A; press(1'b1, 1'b0, 4'b0000);
        check("t6_cap_A", numeroA, 8'h5A);
        check("t6_cap_state", state_o, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
